// File: rtl/txstr_seq_pkg.sv
// Shared definitions for the message sequencer that feeds uart_tx:
// state encoding, ASCII line-control characters and width helpers.
package txstr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_GAP
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Counter/index width for values 0..n-1, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_eol(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

endpackage

// File: rtl/txstr_seq_msg_rom.sv
// Combinational character lookup: character idx of the message literal,
// leftmost character at index 0.
module msg_rom
    import txstr_seq_pkg::*;
#(
    parameter int                   MSG_LEN = 8,
    parameter logic [8*MSG_LEN-1:0] MSG     = {"Nexys2!", ASCII_LF},
    localparam int                  IDX_W   = min1_clog2(MSG_LEN)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       ch
);

    always_comb begin
        ch = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                ch = MSG[8*(MSG_LEN-1-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/txstr_seq.sv
// Feeds a fixed message to uart_tx one character at a time, pacing each
// character on uart_tx's ready handshake; one-shot on go or auto-repeating.
module txstr_seq
    import txstr_seq_pkg::*;
#(
    parameter int                   MSG_LEN    = 8,
    parameter logic [8*MSG_LEN-1:0] MSG        = {"Nexys2!", ASCII_LF},
    parameter bit                   AUTO       = 1'b0,
    parameter int                   GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       go,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done
);

    localparam int IDX_W = min1_clog2(MSG_LEN);
    localparam int GAP_W = min1_clog2(GAP_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [7:0]       data_nxt;
    logic             start_nxt;
    logic             done_nxt;
    logic [7:0]       rom_ch;

    msg_rom #(
        .MSG_LEN (MSG_LEN),
        .MSG     (MSG)
    ) u_rom (
        .idx (idx),
        .ch  (rom_ch)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        data_nxt  = tx_data;
        start_nxt = tx_start;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                data_nxt  = rom_ch;
                start_nxt = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // Start and data stay put until uart_tx is ready to take them.
                if (tx_start && tx_ready) begin
                    start_nxt = 1'b0;
                    state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_ready) state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        idx_nxt   = '0;
                        gap_nxt   = '0;
                        state_nxt = AUTO ? ST_GAP : ST_IDLE;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if ((GAP_CYCLES == 0) || (gap_cnt == GAP_LAST)) begin
                    state_nxt = ST_LOAD;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            idx      <= '0;
            gap_cnt  <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            gap_cnt  <= gap_nxt;
            tx_data  <= data_nxt;
            tx_start <= start_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_txstr_seq.sv
// Bench for txstr_seq: three configurations against a uart_tx ready model,
// a message-level reference model and directed literal expectations.
module tb_txstr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rstn, go, hold, busy, done, start, rdy;
    logic [2:0]      mrdy = 3'b111;
    logic [2:0][7:0] data;
    assign rdy = mrdy & ~hold;

    txstr_seq #(.MSG_LEN(3), .MSG("Hi!"), .AUTO(1'b0), .GAP_CYCLES(1000)) u0 (
        .clk(clk), .rstn(rstn[0]), .go(go[0]), .tx_ready(rdy[0]),
        .tx_data(data[0]), .tx_start(start[0]), .busy(busy[0]), .done(done[0]));
    txstr_seq #(.MSG_LEN(3), .MSG("Hi!"), .AUTO(1'b1), .GAP_CYCLES(5)) u1 (
        .clk(clk), .rstn(rstn[1]), .go(go[1]), .tx_ready(rdy[1]),
        .tx_data(data[1]), .tx_start(start[1]), .busy(busy[1]), .done(done[1]));
    txstr_seq #(.MSG_LEN(1), .MSG("A"), .AUTO(1'b0), .GAP_CYCLES(1000)) u2 (
        .clk(clk), .rstn(rstn[2]), .go(go[2]), .tx_ready(rdy[2]),
        .tx_data(data[2]), .tx_start(start[2]), .busy(busy[2]), .done(done[2]));

    int nvec = 0, nfail = 0, cyc = 0;
    logic [7:0] exp_msg [3][3] = '{'{8'h48, 8'h69, 8'h21}, '{8'h48, 8'h69, 8'h21}, '{8'h41, 8'h00, 8'h00}};
    int msg_len [3] = '{3, 3, 1};
    int auto_gap[3] = '{-1, 5, -1};
    int frame_len[3] = '{20, 20, 20};
    int fcnt[3] = '{0, 0, 0};

    // Reference model state
    bit m_active[3], m_want[3], m_infr[3], m_low[3], m_last[3], m_done[3], m_rst[3];
    int m_pos[3], m_start_at[3];
    bit started = 1'b0;

    // Observations of the DUT for the directed checks
    logic [7:0] acc_log[3][64];
    int acc_n[3] = '{0, 0, 0};
    int done_cnt[3] = '{0, 0, 0};
    int last_rise[3] = '{0, 0, 0};
    int gap_meas[3] = '{-1, -1, -1};
    bit after_done[3], prev_rdy[3], prev_start[3];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // uart_tx ready model: ready drops for frame_len cycles after each accept.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (fcnt[k] != 0) begin
                if (fcnt[k] == 1) mrdy[k] <= 1'b1;
                fcnt[k] <= fcnt[k] - 1;
            end else if (start[k] && rdy[k]) begin
                mrdy[k] <= 1'b0;
                fcnt[k] <= frame_len[k];
            end
        end
    end

    // Message-level model plus DUT observation, evaluated on each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (!rstn[k]) begin
                m_active[k] = 0; m_want[k] = 0; m_infr[k] = 0; m_low[k] = 0;
                m_pos[k] = 0; m_start_at[k] = -1; m_done[k] = 0; m_rst[k] = 1;
            end else begin
                m_rst[k] = 0;
                m_done[k] = 0;
                if (!m_active[k] && go[k]) begin
                    m_active[k] = 1;
                    m_start_at[k] = cyc + 1;
                end
                if (m_want[k] && rdy[k]) begin
                    m_want[k] = 0; m_infr[k] = 1; m_low[k] = 0;
                    m_last[k] = (m_pos[k] == msg_len[k] - 1);
                    m_pos[k] = m_last[k] ? 0 : m_pos[k] + 1;
                end else if (m_infr[k]) begin
                    if (!rdy[k]) begin
                        m_low[k] = 1;
                    end else if (m_low[k]) begin
                        m_infr[k] = 0;
                        if (m_last[k]) begin
                            m_done[k] = 1;
                            if (auto_gap[k] >= 0)
                                m_start_at[k] = cyc + ((auto_gap[k] > 0) ? auto_gap[k] : 1) + 1;
                            else
                                m_active[k] = 0;
                        end else begin
                            m_start_at[k] = cyc + 1;
                        end
                    end
                end
                if (m_start_at[k] == cyc) begin
                    m_want[k] = 1;
                    m_start_at[k] = -1;
                end
            end

            if (start[k] && rdy[k] && acc_n[k] < 64) begin
                acc_log[k][acc_n[k]] = data[k];
                acc_n[k]++;
            end
            if (rdy[k] && !prev_rdy[k]) last_rise[k] = cyc - 1;
            if (start[k] && !prev_start[k] && after_done[k]) begin
                gap_meas[k] = cyc - 1 - last_rise[k];
                after_done[k] = 0;
            end
            if (done[k]) begin
                done_cnt[k]++;
                after_done[k] = 1;
            end
            prev_rdy[k] = rdy[k];
            prev_start[k] = start[k];
        end
        started = 1'b1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d tx_start", k), int'(start[k]), int'(m_want[k]));
                check($sformatf("u%0d busy", k), int'(busy[k]), int'(m_active[k]));
                check($sformatf("u%0d done", k), int'(done[k]), int'(m_done[k]));
                if (m_want[k])
                    check($sformatf("u%0d tx_data", k), int'(data[k]), int'(exp_msg[k][m_pos[k]]));
                if (m_rst[k])
                    check($sformatf("u%0d reset tx_data", k), int'(data[k]), 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go(input int k);
        go[k] = 1'b1;
        @(negedge clk);
        go[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int t = 0;
        while (done[k] !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("u%0d done within %0d cycles", k, budget), int'(done[k] === 1'b1), 1);
        @(negedge clk);
    endtask

    task automatic wait_acc(input int k, input int n, input int budget);
        int t = 0;
        while (acc_n[k] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("u%0d accept count reached", k), acc_n[k], n);
    endtask

    initial begin
        int base, base2, d0;
        rstn = 3'b000; go = 3'b000; hold = 3'b000;
        cycles(3);
        check("u0 reset tx_data literal", int'(data[0]), 0);
        check("u0 reset tx_start literal", int'(start[0]), 0);
        check("u0 reset busy literal", int'(busy[0]), 0);
        rstn = 3'b111;
        cycles(2);

        // One-shot "Hi!"
        base = acc_n[0]; d0 = done_cnt[0];
        pulse_go(0);
        wait_done(0, 400);
        check("t1 accepts", acc_n[0] - base, 3);
        check("t1 byte0", int'(acc_log[0][base]), 8'h48);
        check("t1 byte1", int'(acc_log[0][base+1]), 8'h69);
        check("t1 byte2", int'(acc_log[0][base+2]), 8'h21);
        check("t1 done pulses", done_cnt[0] - d0, 1);
        check("t1 busy cleared", int'(busy[0]), 0);
        cycles(30);
        check("t1 no further accepts", acc_n[0] - base, 3);

        // go held high for 200 cycles inside a long message
        frame_len[0] = 100;
        base = acc_n[0]; d0 = done_cnt[0];
        go[0] = 1'b1;
        cycles(200);
        go[0] = 1'b0;
        wait_done(0, 600);
        check("t2 one message accepts", acc_n[0] - base, 3);
        check("t2 one done", done_cnt[0] - d0, 1);
        frame_len[0] = 20;
        cycles(5);
        pulse_go(0);
        wait_done(0, 400);
        check("t2 second message accepts", acc_n[0] - base, 6);
        check("t2 second message byte0", int'(acc_log[0][base+3]), 8'h48);

        // Reset while character 1 is in flight
        base = acc_n[0];
        pulse_go(0);
        wait_acc(0, base + 2, 200);
        cycles(5);
        rstn[0] = 1'b0;
        cycles(1);
        rstn[0] = 1'b1;
        check("t4 tx_start after reset", int'(start[0]), 0);
        check("t4 tx_data after reset", int'(data[0]), 0);
        check("t4 busy after reset", int'(busy[0]), 0);
        base2 = acc_n[0];
        pulse_go(0);
        cycles(2);
        check("t4 start held while frame runs", int'(start[0]), 1);
        check("t4 data held while frame runs", int'(data[0]), 8'h48);
        check("t4 no accept yet", acc_n[0] - base2, 0);
        wait_done(0, 400);
        check("t4 accepts after reset", acc_n[0] - base2, 3);
        check("t4 first byte after reset", int'(acc_log[0][base2]), 8'h48);

        // tx_ready stuck low for 100 cycles
        hold[0] = 1'b1;
        base = acc_n[0];
        pulse_go(0);
        cycles(100);
        check("t5 start held", int'(start[0]), 1);
        check("t5 data held", int'(data[0]), 8'h48);
        check("t5 no accept while not ready", acc_n[0] - base, 0);
        hold[0] = 1'b0;
        wait_done(0, 400);
        check("t5 accepts after release", acc_n[0] - base, 3);

        // Auto-repeat with a 5-cycle gap
        pulse_go(1);
        wait_done(1, 400);
        for (int t = 0; t < 50 && gap_meas[1] < 0; t++) @(negedge clk);
        check("t3 final rise to restart", gap_meas[1], 7);
        wait_done(1, 400);
        check("t3 done pulses", done_cnt[1], 2);
        check("t3 repeat byte0", int'(acc_log[1][3]), 8'h48);
        check("t3 repeat byte1", int'(acc_log[1][4]), 8'h69);
        check("t3 repeat byte2", int'(acc_log[1][5]), 8'h21);
        check("t3 busy through gap", int'(busy[1]), 1);

        // Single-character message
        pulse_go(2);
        wait_done(2, 200);
        check("t6 accepts", acc_n[2], 1);
        check("t6 byte", int'(acc_log[2][0]), 8'h41);
        check("t6 done pulses", done_cnt[2], 1);
        check("t6 busy cleared", int'(busy[2]), 0);
        pulse_go(2);
        wait_done(2, 200);
        check("t6 second accepts", acc_n[2], 2);
        check("t6 second byte", int'(acc_log[2][1]), 8'h41);

        cycles(5);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", nvec, nfail);
        $fatal(1, "watchdog");
    end

endmodule
